memory_arbiter: RTL and testbench

Shares the single-port, word-addressed 32-bit `random_access_memory` between the instruction-fetch path and the data (load/store) path of `control_unit`. It accepts at most one request per cycle and gives the data port priority. A starvation guard bounds fetch latency. The arbiter drives the RAM's `a/din/rw`, tracks the owner of each 1-cycle RAM access, and routes the response back to that owner. Out-of-range addresses return an error flag and never reach the RAM.

---
 rtl/limb_mem_pkg.sv | 28 ++
 rtl/memory_arbiter_if.sv | 55 +++++
 rtl/fetch_starvation_guard.sv | 47 ++++
 rtl/memory_arbiter.sv | 126 ++++++++++++
 tb/tb_memory_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/limb_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : limb_mem_pkg
// Description : Shared constants and types for the memory arbiter slice:
//               bus widths, RAM depth and response-owner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package limb_mem_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned MEM_DEPTH = 8192;

    // Who the RAM access issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Unsigned range check of a word address against the RAM depth.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return addr < ADDR_W'(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_if
// Description : Fetch port, data port and RAM-side signals of the memory
//               arbiter. The arbiter uses the slave view; requesters and the
//               RAM model use the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if;
    import limb_mem_pkg::*;

    // Instruction-fetch port
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [WORD_W-1:0] if_rsp_data;
    logic              if_rsp_err;

    // Data (load/store) port
    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_we;
    logic              d_rsp_valid;
    logic [WORD_W-1:0] d_rsp_data;
    logic              d_rsp_err;

    // RAM side
    logic [ADDR_W-1:0] mem_a;
    logic [WORD_W-1:0] mem_din;
    logic              mem_rw;
    logic [WORD_W-1:0] mem_dout;

    modport slave (
        input  if_req_valid, if_addr,
        input  d_req_valid, d_addr, d_wdata, d_we,
        input  mem_dout,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_a, mem_din, mem_rw
    );

    modport master (
        output if_req_valid, if_addr,
        output d_req_valid, d_addr, d_wdata, d_we,
        output mem_dout,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_a, mem_din, mem_rw
    );

endinterface
`default_nettype wire

// File: rtl/fetch_starvation_guard.sv
`default_nettype none
// ============================================================================
// Module      : fetch_starvation_guard
// Description : Counts consecutive data grants taken while a fetch waits and
//               forces the next grant to fetch once the limit is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_starvation_guard #(
    parameter int unsigned STARVE_LIMIT = 4   // legal range 1..15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic if_req_valid_i,
    input  wire logic d_grant_i,
    input  wire logic if_grant_i,
    output logic      fetch_force_o
);

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    // Next count: clear whenever fetch is served or stops asking, otherwise
    // count data wins that overtook it, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_grant_i || !if_req_valid_i) begin
            starve_cnt_d = 4'd0;
        end else if (d_grant_i && (starve_cnt_q < C_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign fetch_force_o = if_req_valid_i && (starve_cnt_q >= C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one single-port RAM between the fetch and data paths.
//               Data has priority, bounded by a fetch starvation guard. One
//               access per cycle; the response returns to its owner one
//               cycle later. Out-of-range addresses never reach the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import limb_mem_pkg::*;
#(
    parameter int unsigned DEPTH        = MEM_DEPTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    memory_arbiter_if.slave  bus
);

    logic              active_q;
    logic              fetch_force;
    logic              d_grant;
    logic              if_grant;
    logic [ADDR_W-1:0] grant_addr;
    logic              grant_in_range;
    logic              issue;
    logic [ADDR_W-1:0] mem_a_q;

    owner_e            owner_q,    owner_d;
    logic              err_q,      err_d;
    logic              is_write_q, is_write_d;
    logic [WORD_W-1:0] rsp_data;

    // Grants are enabled from the first clock edge after reset release, so
    // reset deassertion is only ever observed synchronously by the datapath.
    // Assertion drops the enable immediately, which cancels any grant (and
    // RAM write) being presented in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    fetch_starvation_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_guard (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req_valid_i (bus.if_req_valid),
        .d_grant_i      (d_grant),
        .if_grant_i     (if_grant),
        .fetch_force_o  (fetch_force)
    );

    // Data wins unless the guard says fetch has waited long enough.
    assign d_grant  = active_q && bus.d_req_valid && !fetch_force;
    assign if_grant = active_q && bus.if_req_valid && !d_grant;

    assign bus.d_req_ready  = d_grant;
    assign bus.if_req_ready = if_grant;

    assign grant_addr     = d_grant ? bus.d_addr : bus.if_addr;
    assign grant_in_range = addr_in_range(grant_addr, DEPTH);
    assign issue          = (d_grant || if_grant) && grant_in_range;

    // RAM drive: the address only moves on an issued access, so an idle or
    // rejected cycle re-reads the last location and never writes.
    assign bus.mem_a   = issue ? grant_addr : mem_a_q;
    assign bus.mem_rw  = issue && d_grant && bus.d_we;
    assign bus.mem_din = (issue && d_grant) ? bus.d_wdata : '0;

    // Remember the driven RAM address for cycles without an access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_a_q <= '0;
        end else begin
            mem_a_q <= bus.mem_a;
        end
    end

    // Response bookkeeping captured at grant time.
    always_comb begin
        owner_d    = OWN_NONE;
        err_d      = 1'b0;
        is_write_d = 1'b0;
        if (d_grant) begin
            owner_d    = OWN_D;
            err_d      = !grant_in_range;
            is_write_d = bus.d_we;
        end else if (if_grant) begin
            owner_d    = OWN_IF;
            err_d      = !grant_in_range;
        end
    end

    // Response tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            err_q      <= 1'b0;
            is_write_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            err_q      <= err_d;
            is_write_q <= is_write_d;
        end
    end

    // Read data is only meaningful for an in-range read; stores and errors
    // return zero.
    assign rsp_data = ((owner_q != OWN_NONE) && !err_q && !is_write_q)
                      ? bus.mem_dout : '0;

    assign bus.if_rsp_valid = (owner_q == OWN_IF);
    assign bus.if_rsp_err   = (owner_q == OWN_IF) && err_q;
    assign bus.if_rsp_data  = (owner_q == OWN_IF) ? rsp_data : '0;

    assign bus.d_rsp_valid  = (owner_q == OWN_D);
    assign bus.d_rsp_err    = (owner_q == OWN_D) && err_q;
    assign bus.d_rsp_data   = (owner_q == OWN_D) ? rsp_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter with a RAM model, a
//               behavioural reference of the grant rules and a response
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;
    import limb_mem_pkg::*;

    localparam int unsigned C_DEPTH = 8192;
    localparam int unsigned C_LIMIT = 4;

    typedef struct {
        owner_e      owner;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    memory_arbiter_if u_bus();

    memory_arbiter #(
        .DEPTH        (C_DEPTH),
        .STARVE_LIMIT (C_LIMIT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- RAM model (registered read, write at clock edge) ----
    logic [31:0] ram [C_DEPTH];
    bit          ram_init = 1'b1;

    function automatic logic [31:0] init_val(input int unsigned i);
        if (i == 5) return 32'hE3A01001;
        return (i * 32'h9E3779B9) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < C_DEPTH; i++) ram[i] <= init_val(i);
        end else begin
            if (u_bus.mem_rw && (u_bus.mem_a < C_DEPTH))
                ram[u_bus.mem_a[12:0]] <= u_bus.mem_din;
            if (u_bus.mem_a < C_DEPTH)
                u_bus.mem_dout <= ram[u_bus.mem_a[12:0]];
        end
    end

    // ---------------- reference state -----------------------------------
    logic [31:0] ref_mem [C_DEPTH];
    int unsigned ref_waited;       // data wins since the current fetch began waiting
    logic [31:0] ref_last_a;
    exp_t        exp_q[$];

    // pending requests held by the stimulus until accepted
    logic        pif_v, pd_v, pd_we;
    logic [31:0] pif_a, pd_a, pd_wd;
    logic        g_if, g_d;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decision for the current cycle, run at the falling edge.
    task automatic model_step();
        logic        dg, ig, inr, iss, wr;
        logic [31:0] ga, ea;
        exp_t        e;
        dg  = pd_v && (!pif_v || (ref_waited < C_LIMIT));
        ig  = pif_v && !dg;
        ga  = dg ? pd_a : pif_a;
        inr = (ga < C_DEPTH);
        iss = (dg || ig) && inr;
        wr  = iss && dg && pd_we;
        ea  = iss ? ga : ref_last_a;
        chk("ready", 72'({u_bus.if_req_ready, u_bus.d_req_ready}), 72'({ig, dg}));
        chk("mem_rw_a", 72'({u_bus.mem_rw, u_bus.mem_a}), 72'({wr, ea}));
        if (wr) chk("mem_din", 72'(u_bus.mem_din), 72'(pd_wd));
        e.owner = dg ? OWN_D : (ig ? OWN_IF : OWN_NONE);
        e.err   = (dg || ig) && !inr;
        e.data  = (iss && !wr) ? ref_mem[ga[12:0]] : 32'd0;
        exp_q.push_back(e);
        if (wr) ref_mem[ga[12:0]] = pd_wd;
        ref_last_a = ea;
        if (ig || !pif_v)  ref_waited = 0;
        else if (dg && ref_waited < C_LIMIT) ref_waited++;
        g_if = ig;
        g_d  = dg;
        if (ig) pif_v = 1'b0;
        if (dg) pd_v  = 1'b0;
    endtask

    task automatic do_cycle();
        @(posedge clk);
        #1;
        u_bus.if_req_valid = pif_v;
        u_bus.if_addr      = pif_a;
        u_bus.d_req_valid  = pd_v;
        u_bus.d_addr       = pd_a;
        u_bus.d_wdata      = pd_wd;
        u_bus.d_we         = pd_we;
        @(negedge clk);
        model_step();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'(C_DEPTH + $urandom_range(0, 3));
        if (r == 1) return $urandom;
        if (r == 2) return 32'(C_DEPTH - 1);
        return 32'($urandom_range(0, 31));
    endfunction

    // ---------------- response monitor / scoreboard ---------------------
    initial begin
        exp_t        e;
        logic [67:0] ev, av;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin
                e.owner = OWN_NONE; e.err = 1'b0; e.data = 32'd0;
            end
            ev = {e.owner == OWN_IF, (e.owner == OWN_IF) && e.err,
                  (e.owner == OWN_IF) ? e.data : 32'd0,
                  e.owner == OWN_D,  (e.owner == OWN_D) && e.err,
                  (e.owner == OWN_D) ? e.data : 32'd0};
            av = {u_bus.if_rsp_valid, u_bus.if_rsp_err, u_bus.if_rsp_data,
                  u_bus.d_rsp_valid,  u_bus.d_rsp_err,  u_bus.d_rsp_data};
            chk("rsp", 72'(av), 72'(ev));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ------------------------------------------
    initial begin
        for (int i = 0; i < C_DEPTH; i++) ref_mem[i] = init_val(i);
        ref_waited = 0; ref_last_a = 32'd0;
        pif_v = 0; pd_v = 0; pd_we = 0; pif_a = 0; pd_a = 0; pd_wd = 0;
        // Requests are present during reset and must be ignored.
        u_bus.if_req_valid = 1'b1; u_bus.if_addr = 32'd3;
        u_bus.d_req_valid  = 1'b1; u_bus.d_addr  = 32'd4;
        u_bus.d_wdata = 32'hFFFF_FFFF; u_bus.d_we = 1'b1;
        #1 rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ram_init = 1'b0;
            chk("reset_outs", 72'({u_bus.if_req_ready, u_bus.d_req_ready, u_bus.mem_rw,
                                  u_bus.mem_a, u_bus.mem_din}), 72'd0);
        end
        @(posedge clk); #1;
        u_bus.if_req_valid = 1'b0; u_bus.d_req_valid = 1'b0; u_bus.d_we = 1'b0;
        rst_n = 1'b1;

        // Fetch from address 5.
        pif_v = 1; pif_a = 32'd5; do_cycle();
        do_cycle();

        // Store then load to the same address on consecutive cycles.
        pd_v = 1; pd_a = 32'd100; pd_wd = 32'hDEADBEEF; pd_we = 1; do_cycle();
        pd_v = 1; pd_a = 32'd100; pd_wd = 32'd0;        pd_we = 0; do_cycle();
        do_cycle();

        // Both ports continuously valid: D,D,D,D,IF repeating.
        for (int i = 0; i < 20; i++) begin
            if (!pif_v) begin pif_v = 1; pif_a = 32'($urandom_range(0, 63)); end
            if (!pd_v) begin
                pd_v = 1; pd_a = 32'($urandom_range(0, 63));
                pd_we = 1'($urandom_range(0, 1)); pd_wd = $urandom;
            end
            do_cycle();
            chk("starve_pattern", 72'({g_if, g_d}), 72'(((i % 5) == 4) ? 2'b10 : 2'b01));
        end
        pif_v = 0; pd_v = 0;
        do_cycle();

        // Address boundary.
        pd_v = 1; pd_a = 32'd8192;       pd_we = 0; do_cycle();
        pd_v = 1; pd_a = 32'd8191;       pd_we = 0; do_cycle();
        pd_v = 1; pd_a = 32'hFFFF_FFFF;  pd_we = 1; pd_wd = 32'h1234_5678; do_cycle();
        pif_v = 1; pif_a = 32'h0001_0000; do_cycle();
        pif_v = 1; pif_a = 32'd8191;      do_cycle();

        // Idle.
        for (int i = 0; i < 20; i++) do_cycle();

        // Randomised traffic with held payloads.
        for (int i = 0; i < 600; i++) begin
            if (!pif_v && $urandom_range(0, 99) < 60) begin pif_v = 1; pif_a = rand_addr(); end
            if (!pd_v && $urandom_range(0, 99) < 60) begin
                pd_v = 1; pd_a = rand_addr();
                pd_we = 1'($urandom_range(0, 1)); pd_wd = $urandom;
            end
            do_cycle();
        end
        pif_v = 0; pd_v = 0;
        do_cycle();

        // Reset asserted while a store to address 7 is being presented.
        @(posedge clk); #1;
        u_bus.d_req_valid = 1'b1; u_bus.d_addr = 32'd7; u_bus.d_we = 1'b1;
        u_bus.d_wdata = ~ref_mem[7];
        u_bus.if_req_valid = 1'b1; u_bus.if_addr = 32'd9;
        #1 rst_n = 1'b0;
        exp_q.delete();
        ref_waited = 0; ref_last_a = 32'd0;
        @(negedge clk);
        chk("midrst_outs", 72'({u_bus.if_req_ready, u_bus.d_req_ready, u_bus.mem_rw}), 72'd0);
        @(posedge clk); #3;
        chk("midrst_mem7", 72'(ram[7]), 72'(ref_mem[7]));
        u_bus.d_req_valid = 1'b0; u_bus.if_req_valid = 1'b0; u_bus.d_we = 1'b0;
        rst_n = 1'b1;
        chk("midrst_starve", 72'(u_dut.u_guard.starve_cnt_q), 72'd0);
        for (int i = 0; i < 3; i++) do_cycle();
        pd_v = 1; pd_a = 32'd7; pd_we = 0; do_cycle();
        do_cycle();
        do_cycle();

        @(posedge clk); #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
